instr_fetch_unit: RTL and testbench

- Producer end of the opcode/control interface. Holds the PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents each word, with its opcode field, to the control decoder and datapath over a valid/ready handshake.
- On each accepted instruction, samples the decoder's Branch/Jump outputs and the ALU Zero flag, then computes the next PC internally.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, valid/ready instruction
// port toward decoder/datapath, and the decoder/ALU feedback sampled on acceptance.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_cur;
    logic [31:0] pc_plus4;
    logic [1:0]  Branch;
    logic        Jump;
    logic        Zero;

    modport master (
        output imem_req, imem_addr, instr, op, instr_valid, pc_cur, pc_plus4,
        input  imem_ack, imem_rdata, instr_ready, Branch, Jump, Zero
    );

    modport slave (
        input  imem_req, imem_addr, instr, op, instr_valid, pc_cur, pc_plus4,
        output imem_ack, imem_rdata, instr_ready, Branch, Jump, Zero
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word at a time over req/ack,
// presents it over valid/ready and resolves branch/jump targets on acceptance.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus,
    output logic [CNT_W-1:0]       retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } stateT;

    // Low address bits are forced to zero so a misaligned parameter cannot leak out.
    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE          = CNT_W'(1);

    stateT             state;
    stateT             stateNext;
    logic [31:0]       pc;
    logic [31:0]       pcPlus4;
    logic [31:0]       instrReg;
    logic [31:0]       nextPc;
    logic [CNT_W-1:0]  retiredCnt;
    logic              fetchDone;
    logic              accept;

    function automatic logic signed [31:0] branchOffset(input logic [31:0] word);
        logic signed [31:0] offset;
        offset = signed'({{14{word[15]}}, word[15:0], 2'b00});
        return offset;
    endfunction

    function automatic logic [31:0] calcNextPc(
        input logic [31:0] pcP4,
        input logic [31:0] word,
        input logic [1:0]  br,
        input logic        jmp,
        input logic        zf
    );
        logic taken;
        taken = (br[0] & zf) | (br[1] & ~zf);
        if (jmp)
            return {pcP4[31:28], word[25:0], 2'b00};
        else if (taken)
            return pcP4 + $unsigned(branchOffset(word));
        else
            return pcP4;
    endfunction

    assign fetchDone = (state == FETCH) && bus.imem_ack;
    assign accept    = (state == HOLD) && bus.instr_ready;
    assign pcPlus4   = pc + 32'd4;
    assign nextPc    = calcNextPc(pcPlus4, instrReg, bus.Branch, bus.Jump, bus.Zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = FETCH;
            FETCH:   if (bus.imem_ack) stateNext = HOLD;
            HOLD:    if (bus.instr_ready) stateNext = FETCH;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only; no input reaches them combinationally.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        case (state)
            FETCH:   bus.imem_req    = 1'b1;
            HOLD:    bus.instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC_ALIGNED;
            instrReg   <= 32'h0000_0000;
            retiredCnt <= '0;
        end else begin
            if (fetchDone)
                instrReg <= bus.imem_rdata;
            if (accept) begin
                pc         <= nextPc;
                retiredCnt <= retiredCnt + CNT_ONE;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.pc_cur    = pc;
    assign bus.pc_plus4  = pcPlus4;
    assign bus.instr     = instrReg;
    assign bus.op        = instrReg[31:26];
    assign retired       = retiredCnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed branch/jump/wrap scenarios plus
// randomized traffic checked against an arithmetic next-PC reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam longint      TWO32    = 64'h1_0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] retired;
    int          passCnt;
    int          totalCnt;
    int          cyc;
    logic [31:0] expPc;
    logic [31:0] expRetired;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .CNT_W    (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rType();
        return {6'h00, 26'($urandom)};
    endfunction

    // Reference: next PC from plain integer arithmetic, wrapped modulo 2^32.
    function automatic logic [31:0] refNextPc(input logic [31:0] pcIn, input logic [31:0] word,
                                              input logic [1:0] br, input logic jmp, input logic zf);
        longint p4, w, imm, tgt;
        p4 = (longint'(pcIn) + 4) % TWO32;
        w  = longint'(word);
        if (jmp) begin
            tgt = (p4 / 64'h1000_0000) * 64'h1000_0000 + (w % 64'h400_0000) * 4;
        end else begin
            imm = w % 65536;
            if (imm >= 32768) imm = imm - 65536;
            if ((br == 2'd1 && zf) || (br == 2'd2 && !zf) || br == 2'd3)
                tgt = p4 + imm * 4;
            else
                tgt = p4;
        end
        tgt = ((tgt % TWO32) + TWO32) % TWO32;
        return 32'(tgt);
    endfunction

    // One complete transaction: fetch with ackDelay stall cycles, hold for readyDelay cycles, accept.
    task automatic doFetch(input logic [31:0] word, input int ackDelay, input int readyDelay,
                           input logic [1:0] br, input logic jmp, input logic zf);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        totalCnt++;
        if (bus.imem_req !== 1'b1) $display("FAIL reqTimeout: imem_req=%b after %0d cycles, required 1", bus.imem_req, n);
        else passCnt++;
        totalCnt++;
        if (bus.imem_addr !== expPc) $display("FAIL fetchAddr: got %h required %h", bus.imem_addr, expPc);
        else passCnt++;
        for (int i = 0; i < ackDelay; i++) begin
            bus.imem_ack    = 1'b0;
            bus.instr_ready = 1'($urandom_range(0, 1));
            tick();
            totalCnt++;
            if (bus.imem_addr !== expPc || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0)
                $display("FAIL fetchStall: addr=%h req=%b valid=%b required addr=%h req=1 valid=0",
                         bus.imem_addr, bus.imem_req, bus.instr_valid, expPc);
            else passCnt++;
        end
        bus.instr_ready = 1'b0;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = word;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom();
        totalCnt++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0)
            $display("FAIL holdEntry: valid=%b req=%b required valid=1 req=0", bus.instr_valid, bus.imem_req);
        else passCnt++;
        totalCnt++;
        if (bus.instr !== word) $display("FAIL instrWord: got %h required %h", bus.instr, word);
        else passCnt++;
        totalCnt++;
        if (bus.op !== word[31:26]) $display("FAIL opField: got %h required %h", bus.op, word[31:26]);
        else passCnt++;
        totalCnt++;
        if (bus.pc_cur !== expPc || bus.pc_plus4 !== expPc + 32'd4)
            $display("FAIL pcCur: pc_cur=%h pc_plus4=%h required %h %h", bus.pc_cur, bus.pc_plus4, expPc, expPc + 32'd4);
        else passCnt++;
        for (int i = 0; i < readyDelay; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'($urandom_range(0, 1));
            bus.imem_rdata  = $urandom();
            tick();
            totalCnt++;
            if (bus.instr !== word || bus.pc_cur !== expPc || bus.instr_valid !== 1'b1 || retired !== expRetired)
                $display("FAIL holdStable: instr=%h pc=%h valid=%b retired=%0d required %h %h 1 %0d",
                         bus.instr, bus.pc_cur, bus.instr_valid, retired, word, expPc, expRetired);
            else passCnt++;
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.Branch      = br;
        bus.Jump        = jmp;
        bus.Zero        = zf;
        tick();
        bus.instr_ready = 1'b0;
        bus.Branch      = 2'($urandom_range(0, 3));
        bus.Jump        = 1'($urandom_range(0, 1));
        bus.Zero        = 1'($urandom_range(0, 1));
        expRetired = expRetired + 32'd1;
        expPc      = refNextPc(expPc, word, br, jmp, zf);
        totalCnt++;
        if (retired !== expRetired) $display("FAIL retiredCount: got %0d required %0d", retired, expRetired);
        else passCnt++;
        totalCnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== expPc)
            $display("FAIL nextFetch: valid=%b req=%b addr=%h required 0 1 %h",
                     bus.instr_valid, bus.imem_req, bus.imem_addr, expPc);
        else passCnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        totalCnt++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("FAIL resetHandshake: req=%b valid=%b required 0 0", bus.imem_req, bus.instr_valid);
        else passCnt++;
        totalCnt++;
        if (bus.imem_addr !== RESET_PC || bus.op !== 6'h00 || bus.instr !== 32'h0 || retired !== 32'h0)
            $display("FAIL resetValues: addr=%h op=%h instr=%h retired=%0d required %h 0 0 0",
                     bus.imem_addr, bus.op, bus.instr, retired, RESET_PC);
        else passCnt++;
        @(negedge clk);
        rst_n      = 1'b1;
        expPc      = RESET_PC;
        expRetired = 32'h0;
    endtask

    task automatic test_first_fetch();
        totalCnt++;
        if (bus.imem_req !== 1'b0) $display("FAIL idleReq: got %b required 0", bus.imem_req);
        else passCnt++;
        tick();
        totalCnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0)
            $display("FAIL firstFetch: req=%b addr=%h valid=%b required 1 00000000 0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        else passCnt++;
    endtask

    task automatic test_sequential();
        doFetch(rType(), 1, 0, 2'b00, 1'b0, 1'b0);
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        totalCnt++;
        if (retired !== 32'd3 || bus.imem_addr !== 32'h0000_000C)
            $display("FAIL sequential: retired=%0d addr=%h required 3 0000000c", retired, bus.imem_addr);
        else passCnt++;
    endtask

    task automatic test_branch();
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        doFetch(32'h1000_FFFE, 0, 0, 2'b01, 1'b0, 1'b1);
        totalCnt++;
        if (bus.imem_addr !== 32'h0000_000C) $display("FAIL beqTaken: got %h required 0000000c", bus.imem_addr);
        else passCnt++;
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        doFetch(32'h1000_FFFE, 0, 0, 2'b01, 1'b0, 1'b0);
        totalCnt++;
        if (bus.imem_addr !== 32'h0000_0014) $display("FAIL beqNotTaken: got %h required 00000014", bus.imem_addr);
        else passCnt++;
        doFetch(32'h1000_FFFE, 0, 0, 2'b01, 1'b0, 1'b1);
        doFetch(32'h1400_0003, 0, 0, 2'b10, 1'b0, 1'b0);
        totalCnt++;
        if (bus.imem_addr !== 32'h0000_0020) $display("FAIL bneTaken: got %h required 00000020", bus.imem_addr);
        else passCnt++;
    endtask

    task automatic test_jump();
        doFetch(32'h0800_0100, 0, 0, 2'b01, 1'b1, 1'b1);
        totalCnt++;
        if (bus.imem_addr !== 32'h0000_0400) $display("FAIL jumpPriority: got %h required 00000400", bus.imem_addr);
        else passCnt++;
    endtask

    task automatic test_wrap();
        doFetch(32'h1000_FEFE, 0, 0, 2'b01, 1'b0, 1'b1);
        totalCnt++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL branchWrap: got %h required fffffffc", bus.imem_addr);
        else passCnt++;
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        totalCnt++;
        if (bus.imem_addr !== 32'h0000_0000) $display("FAIL pcWrap: got %h required 00000000", bus.imem_addr);
        else passCnt++;
    endtask

    task automatic test_backpressure();
        doFetch(rType(), 5, 4, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int startCyc;
        startCyc = cyc;
        for (int i = 0; i < 4; i++) doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        totalCnt++;
        if (cyc - startCyc !== 8) $display("FAIL backToBack: %0d cycles for 4 instructions, required 8", cyc - startCyc);
        else passCnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            doFetch($urandom(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        bus.imem_ack = 1'b0;
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        totalCnt++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || retired !== 32'h0 || bus.instr !== 32'h0)
            $display("FAIL resetMidFetch: req=%b addr=%h retired=%0d instr=%h required 0 %h 0 0",
                     bus.imem_req, bus.imem_addr, retired, bus.instr, RESET_PC);
        else passCnt++;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst_n        = 1'b1;
        expPc        = RESET_PC;
        expRetired   = 32'h0;
        tick();
        totalCnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || retired !== 32'h0 || bus.instr !== 32'h0)
            $display("FAIL restartFetch: req=%b addr=%h retired=%0d instr=%h required 1 %h 0 0",
                     bus.imem_req, bus.imem_addr, retired, bus.instr, RESET_PC);
        else passCnt++;
        doFetch(rType(), 0, 0, 2'b00, 1'b0, 1'b0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFC00_0000;
        tick();
        bus.imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        totalCnt++;
        if (bus.instr_valid !== 1'b0 || bus.op !== 6'h00 || retired !== 32'h0)
            $display("FAIL resetMidHold: valid=%b op=%h retired=%0d required 0 00 0", bus.instr_valid, bus.op, retired);
        else passCnt++;
        @(negedge clk);
        rst_n      = 1'b1;
        expPc      = RESET_PC;
        expRetired = 32'h0;
        doFetch(rType(), 1, 1, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        passCnt         = 0;
        totalCnt        = 0;
        cyc             = 0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.Branch      = 2'b00;
        bus.Jump        = 1'b0;
        bus.Zero        = 1'b0;
        expPc           = RESET_PC;
        expRetired      = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
